// File: rtl/w6_link_pkg.sv
// Shared constants for the w6 debug serial link: byte width, bit-counter width
// and the io_dir encodings.
package w6_link_pkg;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = $clog2(BYTE_W);

  localparam logic DIR_RX = 1'b1;
  localparam logic DIR_TX = 1'b0;

  typedef logic [BYTE_W-1:0] byte_t;
endpackage

// File: rtl/w6_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO succeeds
// when a pop happens in the same cycle.
module w6_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             full, do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full | do_pop);

  assign rd_data_o = mem_q[rd_q];
  assign count_o   = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/w6_serial_phy.sv
// Bit-serial host link PHY: synchronises the host pins, deserialises RX bytes
// into a FIFO and serialises TX bytes from a one-entry holding register.
module w6_serial_phy
  import w6_link_pkg::*;
#(
  parameter int RX_DEPTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_clk,
  input  logic              io_dir,
  input  logic              io_in,
  output logic              io_out,
  output logic              io_cts,
  output logic              io_rts,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              rx_overflow
);
  localparam int CW = $clog2(RX_DEPTH) + 1;
  localparam logic [CW-1:0] RX_FULL = CW'(RX_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, dir_sync_q, in_sync_q;
  logic sync_clk, sync_dir, sync_in, prev_clk_q, dir_prev_q;
  logic s_rise, s_fall, dir_chg;

  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [BYTE_W-2:0] shift_rx_q, shift_rx_d;
  byte_t             tx_byte_q, tx_byte_d, hold_q, hold_d;
  logic              tx_busy_q, tx_busy_d, hold_full_q, hold_full_d;
  logic              io_out_q, io_out_d, ovf_q, ovf_d;
  logic              cts_q, alive_q;

  logic              push, pop, fifo_empty, fifo_full, tx_accept;
  byte_t             push_data;
  logic [CW-1:0]     fifo_cnt;

  assign sync_clk = clk_sync_q[SYNC_STAGES-1];
  assign sync_dir = dir_sync_q[SYNC_STAGES-1];
  assign sync_in  = in_sync_q[SYNC_STAGES-1];
  assign s_rise   = sync_clk & ~prev_clk_q;
  assign s_fall   = ~sync_clk & prev_clk_q;
  assign dir_chg  = sync_dir ^ dir_prev_q;

  assign rx_valid    = ~fifo_empty;
  assign pop         = rx_valid & rx_ready;
  assign fifo_full   = (fifo_cnt == RX_FULL);
  assign push_data   = {shift_rx_q, sync_in};
  assign tx_ready    = alive_q & ~hold_full_q;
  assign tx_accept   = tx_valid & tx_ready;
  assign io_out      = io_out_q;
  assign io_rts      = tx_busy_q;
  assign io_cts      = cts_q;
  assign rx_overflow = ovf_q;

  w6_sync_fifo #(
    .DEPTH(RX_DEPTH),
    .WIDTH(BYTE_W)
  ) u_rx_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .rd_data_o  (rx_data),
    .count_o    (fifo_cnt),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    bitcnt_d    = bitcnt_q;
    shift_rx_d  = shift_rx_q;
    tx_byte_d   = tx_byte_q;
    tx_busy_d   = tx_busy_q;
    io_out_d    = io_out_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    push        = 1'b0;

    // A direction flip drops a partial RX byte and rewinds TX to its MSB.
    if (dir_chg) begin
      bitcnt_d = '0;
      if (sync_dir == DIR_TX && tx_busy_q) io_out_d = tx_byte_q[BYTE_W-1];
    end else if (sync_dir == DIR_RX) begin
      if (s_rise) begin
        shift_rx_d = push_data[BYTE_W-2:0];
        bitcnt_d   = bitcnt_q + 1'b1;
        push       = (bitcnt_q == LAST_BIT);
      end
    end else if (tx_busy_q) begin
      if (s_rise) begin
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == LAST_BIT) tx_busy_d = 1'b0;
      end else if (s_fall && bitcnt_q != '0) begin
        io_out_d = tx_byte_q[LAST_BIT - bitcnt_q];
      end
    end else if (hold_full_q) begin
      tx_byte_d   = hold_q;
      tx_busy_d   = 1'b1;
      io_out_d    = hold_q[BYTE_W-1];
      hold_full_d = 1'b0;
    end

    if (tx_accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
    ovf_d = ovf_q | (push & fifo_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '0;
      dir_sync_q  <= '0;
      in_sync_q   <= '0;
      prev_clk_q  <= 1'b0;
      dir_prev_q  <= 1'b0;
      bitcnt_q    <= '0;
      shift_rx_q  <= '0;
      tx_byte_q   <= '0;
      tx_busy_q   <= 1'b0;
      io_out_q    <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ovf_q       <= 1'b0;
      cts_q       <= 1'b0;
      alive_q     <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], io_clk};
      dir_sync_q  <= {dir_sync_q[SYNC_STAGES-2:0], io_dir};
      in_sync_q   <= {in_sync_q[SYNC_STAGES-2:0], io_in};
      prev_clk_q  <= sync_clk;
      dir_prev_q  <= sync_dir;
      bitcnt_q    <= bitcnt_d;
      shift_rx_q  <= shift_rx_d;
      tx_byte_q   <= tx_byte_d;
      tx_busy_q   <= tx_busy_d;
      io_out_q    <= io_out_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ovf_q       <= ovf_d;
      cts_q       <= (fifo_cnt < RX_FULL);
      alive_q     <= 1'b1;
    end
  end
endmodule

// File: tb/tb_w6_serial_phy.sv
// Directed bench for w6_serial_phy: a host-pin driver plus a queue model of the
// RX FIFO contents; one process checks every pop against the model.
module tb_w6_serial_phy;
  localparam int RX_DEPTH    = 4;
  localparam int SYNC_STAGES = 2;
  localparam int H           = 4;   // io_clk half period in clk cycles (clk/8)

  logic       clk = 1'b0, rst = 1'b1;
  logic       io_clk = 1'b0, io_dir = 1'b1, io_in = 1'b0;
  logic       rx_ready = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       io_out, io_cts, io_rts, rx_valid, tx_ready, rx_overflow;
  logic [7:0] rx_data;

  int         n_cmp = 0, n_bad = 0;
  logic [7:0] exp_rx[$];
  logic       ovf_exp = 1'b0;

  always #5 clk = ~clk;

  w6_serial_phy #(.RX_DEPTH(RX_DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .io_clk(io_clk), .io_dir(io_dir), .io_in(io_in),
    .io_out(io_out), .io_cts(io_cts), .io_rts(io_rts),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_overflow(rx_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every pop the consumer performs must return the model's oldest byte.
  always begin
    @(negedge clk);
    #1;
    if (!rst && rx_valid && rx_ready) begin
      if (exp_rx.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rx_pop_unexpected: got %0h expected no data", rx_data);
      end else begin
        chk("rx_pop_data", rx_data, exp_rx.pop_front());
      end
    end
  end

  task automatic host_rx(input logic [7:0] b, input int nbits, output int lat);
    lat = 0;
    for (int i = 0; i < nbits; i++) begin
      io_in = b[7-i];
      repeat (H) @(negedge clk);
      io_clk = 1'b1;
      for (int c = 1; c <= ((i == 7) ? SYNC_STAGES + 3 : H); c++) begin
        @(negedge clk);
        if (lat == 0 && rx_valid) lat = c;
      end
      io_clk = 1'b0;
    end
    if (nbits == 8) begin
      if (exp_rx.size() < RX_DEPTH) exp_rx.push_back(b);
      else ovf_exp = 1'b1;
    end
  endtask

  task automatic host_tx(input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      repeat (H) @(negedge clk);
      got = {got[6:0], io_out};
      io_clk = 1'b1;
      repeat (H) @(negedge clk);
      io_clk = 1'b0;
    end
  endtask

  task automatic tx_send(input logic [7:0] b);
    chk("tx_ready_before_send", tx_ready, 1'b1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    rx_ready = 1'b1;
    n = 0;
    while (exp_rx.size() != 0 && n < 4 * RX_DEPTH + 4) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", exp_rx.size(), 0);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rx_valid_after_drain", rx_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         lat;
    logic [7:0] got;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_io_out", io_out, 1'b0);
    chk("rst_io_cts", io_cts, 1'b0);
    chk("rst_io_rts", io_rts, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_tx_ready", tx_ready, 1'b0);
    chk("rst_rx_overflow", rx_overflow, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_io_cts", io_cts, 1'b1);
    chk("post_rst_tx_ready", tx_ready, 1'b1);
    repeat (6) @(negedge clk);

    // single RX byte
    host_rx(8'hA5, 8, lat);
    chk("rx_latency_in_bound", (lat >= 1 && lat <= SYNC_STAGES + 3), 1'b1);
    chk("rx_data_a5", rx_data, 8'hA5);
    chk("rx_cts_one_byte", io_cts, 1'b1);
    drain();

    // fill past depth
    for (int k = 1; k <= 5; k++) begin
      host_rx(8'(k), 8, lat);
      if (k == 3) chk("cts_after_3", io_cts, 1'b1);
      if (k == 4) chk("cts_after_4", io_cts, (exp_rx.size() < RX_DEPTH));
    end
    chk("cts_full_literal", io_cts, 1'b0);
    chk("ovf_model", rx_overflow, ovf_exp);
    chk("ovf_literal", rx_overflow, 1'b1);
    chk("head_01", rx_data, 8'h01);
    drain();
    repeat (2) @(negedge clk);
    chk("cts_after_drain", io_cts, 1'b1);
    chk("ovf_sticky", rx_overflow, 1'b1);

    // TX 0x3C
    io_dir = 1'b0;
    repeat (6) @(negedge clk);
    chk("rts_idle", io_rts, 1'b0);
    tx_send(8'h3C);
    repeat (3) @(negedge clk);
    chk("rts_before_edge", io_rts, 1'b1);
    chk("first_bit_3c", io_out, 1'b0);
    host_tx(8, got);
    chk("tx_3c", got, 8'h3C);
    repeat (SYNC_STAGES + 3) @(negedge clk);
    chk("rts_after_3c", io_rts, 1'b0);

    // back-to-back 0xFF then 0x00
    tx_send(8'hFF);
    repeat (3) @(negedge clk);
    chk("tx_ready_reassert", tx_ready, 1'b1);
    chk("rts_ff", io_rts, 1'b1);
    tx_send(8'h00);
    @(negedge clk);
    chk("tx_ready_hold_full", tx_ready, 1'b0);
    host_tx(8, got);
    chk("tx_ff", got, 8'hFF);
    host_tx(8, got);
    chk("tx_00", got, 8'h00);
    repeat (SYNC_STAGES + 3) @(negedge clk);
    chk("rts_after_pair", io_rts, 1'b0);

    // direction flip mid RX byte, then pending TX byte
    io_dir = 1'b1;
    repeat (6) @(negedge clk);
    tx_send(8'h81);
    host_rx(8'hFF, 3, lat);
    io_dir = 1'b0;
    repeat (6) @(negedge clk);
    chk("rts_after_flip", io_rts, 1'b1);
    host_tx(8, got);
    chk("tx_81", got, 8'h81);
    repeat (SYNC_STAGES + 3) @(negedge clk);
    chk("no_rx_push_after_flip", rx_valid, 1'b0);

    // reset in the middle of a TX byte
    tx_send(8'hA5);
    repeat (3) @(negedge clk);
    host_tx(4, got);
    chk("tx_a5_half", got, 8'h0A);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_tx_ready", tx_ready, 1'b0);
    chk("mid_rst_rts", io_rts, 1'b0);
    exp_rx.delete();
    ovf_exp = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst2_rts", io_rts, 1'b0);
    chk("post_rst2_io_out", io_out, 1'b0);
    chk("post_rst2_tx_ready", tx_ready, 1'b1);
    chk("post_rst2_rx_valid", rx_valid, 1'b0);
    chk("post_rst2_ovf", rx_overflow, ovf_exp);
    repeat (6) @(negedge clk);
    tx_send(8'h5A);
    repeat (3) @(negedge clk);
    host_tx(8, got);
    chk("tx_5a_after_rst", got, 8'h5A);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
